// File: rtl/pi_initiator.sv
// Requester side of the Pi bus slot: turns single-byte read/write commands into a
// pi_pending/pi_done four-phase handshake and returns one response per command.
module pi_initiator #(
  parameter int ADDR_WIDTH     = 17,
  parameter int TIMEOUT_CYCLES = 255,
  localparam int CNT_W         = $clog2(TIMEOUT_CYCLES + 1)
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_rw_b,
  input  logic                  cmd_incr,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [7:0]            cmd_data,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [7:0]            rsp_data,
  output logic                  rsp_timeout,
  output logic                  pi_pending,
  input  logic                  pi_done,
  output logic                  pi_rw_b,
  output logic [ADDR_WIDTH-1:0] pi_addr,
  output logic [7:0]            pi_data_out,
  input  logic                  pi_read,
  input  logic [7:0]            bus_data_in
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_REQ     = 2'd1,
    S_RELEASE = 2'd2,
    S_RESP    = 2'd3
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic                  r_pending;
  logic                  r_rw_b;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [ADDR_WIDTH-1:0] r_last_addr;
  logic [7:0]            r_data_out;
  logic [7:0]            r_rsp_data;
  logic                  r_rsp_timeout;
  logic [CNT_W-1:0]      r_cnt;

  logic                  w_accept;
  logic                  w_timeout;
  logic                  w_capture;
  logic [ADDR_WIDTH-1:0] w_cmd_addr;

  // A stale pi_done (e.g. a completion arriving after a timeout) blocks new requests.
  assign cmd_ready  = (r_state == S_IDLE) && !pi_done;
  assign w_accept   = cmd_valid && cmd_ready;
  assign w_cmd_addr = cmd_incr ? r_last_addr + ADDR_WIDTH'(1) : cmd_addr;
  assign w_timeout  = (r_state == S_REQ) && !pi_done &&
                      (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
  assign w_capture  = ((r_state == S_REQ) || (r_state == S_RELEASE)) && pi_read && r_rw_b;

  assign rsp_valid   = (r_state == S_RESP);
  assign rsp_data    = r_rsp_data;
  assign rsp_timeout = r_rsp_timeout;
  assign pi_pending  = r_pending;
  assign pi_rw_b     = r_rw_b;
  assign pi_addr     = r_addr;
  assign pi_data_out = r_data_out;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) w_state_nxt = S_REQ;
      end
      S_REQ: begin
        if (pi_done)        w_state_nxt = S_RELEASE;
        else if (w_timeout) w_state_nxt = S_RESP;
      end
      S_RELEASE: begin
        if (!pi_done) w_state_nxt = S_RESP;
      end
      S_RESP: begin
        if (rsp_ready) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_pending     <= 1'b0;
      r_rw_b        <= 1'b1;
      r_addr        <= '0;
      r_last_addr   <= '0;
      r_data_out    <= 8'h00;
      r_rsp_data    <= 8'h00;
      r_rsp_timeout <= 1'b0;
      r_cnt         <= '0;
    end else if (w_accept) begin
      r_pending     <= 1'b1;
      r_rw_b        <= cmd_rw_b;
      r_addr        <= w_cmd_addr;
      r_last_addr   <= w_cmd_addr;
      r_data_out    <= cmd_data;
      r_rsp_data    <= 8'h00;
      r_rsp_timeout <= 1'b0;
      r_cnt         <= '0;
    end else begin
      if (w_capture) r_rsp_data <= bus_data_in;
      // Timeout overrides any read sample taken on the same edge.
      if (r_state == S_REQ) begin
        if (pi_done) begin
          r_pending <= 1'b0;
        end else if (w_timeout) begin
          r_pending     <= 1'b0;
          r_rsp_timeout <= 1'b1;
          r_rsp_data    <= 8'h00;
        end else begin
          r_cnt <= r_cnt + CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_pi_initiator.sv
// Self-checking bench for pi_initiator: bench plays the Pi command source and the
// timing block, predicting address, handshake timing and response data per command.
module tb_pi_initiator;
  localparam int AW = 17;
  localparam int TO = 4;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic          cmd_rw_b = 1'b0;
  logic          cmd_incr = 1'b0;
  logic [AW-1:0] cmd_addr = '0;
  logic [7:0]    cmd_data = 8'h00;
  logic          rsp_valid;
  logic          rsp_ready = 1'b0;
  logic [7:0]    rsp_data;
  logic          rsp_timeout;
  logic          pi_pending;
  logic          pi_done = 1'b0;
  logic          pi_rw_b;
  logic [AW-1:0] pi_addr;
  logic [7:0]    pi_data_out;
  logic          pi_read = 1'b0;
  logic [7:0]    bus_data_in = 8'h00;

  int            n_total = 0;
  int            n_bad = 0;
  logic [AW-1:0] m_last = '0;

  pi_initiator #(.ADDR_WIDTH(AW), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset_n(reset_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_rw_b(cmd_rw_b),
    .cmd_incr(cmd_incr), .cmd_addr(cmd_addr), .cmd_data(cmd_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_timeout(rsp_timeout), .pi_pending(pi_pending), .pi_done(pi_done),
    .pi_rw_b(pi_rw_b), .pi_addr(pi_addr), .pi_data_out(pi_data_out),
    .pi_read(pi_read), .bus_data_in(bus_data_in)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // Drive the read strobe for the next edge; the latest strobed byte is what a read returns.
  task automatic drv_rd(input bit rw, input int fix, inout logic [7:0] ed);
    if (fix >= 0) begin
      pi_read     = 1'b1;
      bus_data_in = 8'(fix);
    end else begin
      pi_read     = 1'($urandom);
      bus_data_in = 8'($urandom);
    end
    if (rw && pi_read) ed = bus_data_in;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_pend"}, 32'(pi_pending), 32'd0);
    chk({tag, "_rw"}, 32'(pi_rw_b), 32'd1);
    chk({tag, "_addr"}, 32'(pi_addr), 32'd0);
    chk({tag, "_dout"}, 32'(pi_data_out), 32'd0);
    chk({tag, "_rvld"}, 32'(rsp_valid), 32'd0);
    chk({tag, "_rdat"}, 32'(rsp_data), 32'd0);
    chk({tag, "_rto"}, 32'(rsp_timeout), 32'd0);
    chk({tag, "_rdy"}, 32'(cmd_ready), 32'd1);
  endtask

  task automatic do_txn(input bit rw, input bit incr, input logic [AW-1:0] addr,
                        input logic [7:0] data, input int dly, input int rel,
                        input int wait_n, input int fix);
    logic [AW-1:0] ea;
    logic [7:0]    ed;
    cmd_valid = 1'b1;
    cmd_rw_b  = rw;
    cmd_incr  = incr;
    cmd_addr  = addr;
    cmd_data  = data;
    #1;
    chk("rdy_idle", 32'(cmd_ready), 32'd1);
    ea     = incr ? m_last + AW'(1) : addr;
    m_last = ea;
    ed     = 8'h00;
    step;
    cmd_valid = 1'b0;
    cmd_addr  = AW'($urandom);
    cmd_data  = 8'($urandom);
    cmd_rw_b  = 1'($urandom);
    chk("acc_pend", 32'(pi_pending), 32'd1);
    chk("acc_addr", 32'(pi_addr), 32'(ea));
    chk("acc_rw", 32'(pi_rw_b), 32'(rw));
    chk("acc_dout", 32'(pi_data_out), 32'(data));
    chk("acc_rdy", 32'(cmd_ready), 32'd0);
    for (int k = 0; k < dly; k++) begin
      drv_rd(rw, fix, ed);
      step;
      chk("req_pend", 32'(pi_pending), 32'd1);
      chk("req_addr", 32'(pi_addr), 32'(ea));
    end
    pi_done = 1'b1;
    drv_rd(rw, fix, ed);
    step;
    chk("done_pend", 32'(pi_pending), 32'd0);
    chk("done_rvld", 32'(rsp_valid), 32'd0);
    chk("done_addr", 32'(pi_addr), 32'(ea));
    chk("done_dout", 32'(pi_data_out), 32'(data));
    for (int k = 0; k < rel; k++) begin
      drv_rd(rw, fix, ed);
      step;
      chk("rel_rvld", 32'(rsp_valid), 32'd0);
      chk("rel_rdy", 32'(cmd_ready), 32'd0);
      chk("rel_rw", 32'(pi_rw_b), 32'(rw));
    end
    pi_done = 1'b0;
    pi_read = 1'b0;
    step;
    chk("rsp_vld", 32'(rsp_valid), 32'd1);
    chk("rsp_data", 32'(rsp_data), 32'(ed));
    chk("rsp_to", 32'(rsp_timeout), 32'd0);
    for (int k = 0; k < wait_n; k++) begin
      step;
      chk("hold_vld", 32'(rsp_valid), 32'd1);
      chk("hold_data", 32'(rsp_data), 32'(ed));
      chk("hold_rdy", 32'(cmd_ready), 32'd0);
    end
    rsp_ready = 1'b1;
    step;
    rsp_ready = 1'b0;
    chk("post_vld", 32'(rsp_valid), 32'd0);
    chk("post_rdy", 32'(cmd_ready), 32'd1);
    chk("post_addr", 32'(pi_addr), 32'(ea));
  endtask

  task automatic do_timeout;
    logic [AW-1:0] ea;
    cmd_valid = 1'b1;
    cmd_rw_b  = 1'b1;
    cmd_incr  = 1'b0;
    cmd_addr  = 17'h0ABCD;
    cmd_data  = 8'h11;
    step;
    cmd_valid = 1'b0;
    ea        = 17'h0ABCD;
    m_last    = ea;
    chk("to_acc_pend", 32'(pi_pending), 32'd1);
    for (int k = 1; k < TO; k++) begin
      pi_read     = 1'b1;
      bus_data_in = 8'h77;
      step;
      chk("to_wait_pend", 32'(pi_pending), 32'd1);
      chk("to_wait_vld", 32'(rsp_valid), 32'd0);
    end
    pi_read     = 1'b1;
    bus_data_in = 8'hEE;
    step;
    pi_read = 1'b0;
    chk("to_pend", 32'(pi_pending), 32'd0);
    chk("to_vld", 32'(rsp_valid), 32'd1);
    chk("to_flag", 32'(rsp_timeout), 32'd1);
    chk("to_data", 32'(rsp_data), 32'd0);
    step;
    step;
    chk("to_hold_flag", 32'(rsp_timeout), 32'd1);
    rsp_ready = 1'b1;
    step;
    rsp_ready = 1'b0;
    chk("to_post_vld", 32'(rsp_valid), 32'd0);
    // Late completion from the timing block, with a new command already waiting.
    cmd_valid = 1'b1;
    cmd_rw_b  = 1'b0;
    cmd_addr  = 17'h00042;
    cmd_data  = 8'h99;
    pi_done   = 1'b1;
    #1;
    chk("late_rdy0", 32'(cmd_ready), 32'd0);
    for (int k = 0; k < 3; k++) begin
      step;
      chk("late_rdy", 32'(cmd_ready), 32'd0);
      chk("late_vld", 32'(rsp_valid), 32'd0);
      chk("late_pend", 32'(pi_pending), 32'd0);
      chk("late_addr", 32'(pi_addr), 32'(ea));
      chk("late_to", 32'(rsp_timeout), 32'd1);
    end
    pi_done = 1'b0;
    #1;
    chk("late_rdy1", 32'(cmd_ready), 32'd1);
  endtask

  initial begin
    logic [AW-1:0] a;
    logic [7:0]    ed;
    step;
    chk_reset_vals("rst_in");
    step;
    reset_n = 1'b1;
    step;
    chk_reset_vals("rst_out");

    do_txn(1'b1, 1'b0, 17'h08000, 8'h00, 2, 1, 0, 8'hA5);
    do_txn(1'b0, 1'b0, 17'h0E810, 8'h3C, 3, 2, 0, -1);
    do_txn(1'b1, 1'b0, 17'h1FFFF, 8'h00, 0, 0, 0, -1);
    do_txn(1'b1, 1'b1, 17'h00123, 8'h00, 1, 0, 0, -1);
    do_txn(1'b1, 1'b0, 17'h00555, 8'h00, 1, 0, 10, 8'h5A);
    do_txn(1'b1, 1'b0, 17'h00700, 8'h00, TO - 1, 0, 0, 8'hC3);

    do_timeout;
    do_txn(1'b0, 1'b0, 17'h00042, 8'h99, 1, 1, 0, -1);

    // Asynchronous reset in the middle of a request.
    cmd_valid = 1'b1;
    cmd_rw_b  = 1'b0;
    cmd_incr  = 1'b0;
    cmd_addr  = 17'h13579;
    cmd_data  = 8'h5E;
    step;
    cmd_valid = 1'b0;
    ed        = 8'h00;
    drv_rd(1'b0, -1, ed);
    step;
    chk("mid_pend", 32'(pi_pending), 32'd1);
    #2;
    reset_n = 1'b0;
    pi_read = 1'b0;
    #1;
    chk_reset_vals("rst_mid");
    step;
    reset_n = 1'b1;
    m_last  = '0;
    do_txn(1'b1, 1'b1, 17'h00000, 8'h00, 1, 1, 1, -1);

    for (int n = 0; n < 40; n++) begin
      a = ($urandom_range(3, 0) == 0) ? AW'(17'h1FFFF - $urandom_range(1, 0)) : AW'($urandom);
      do_txn(1'($urandom), 1'($urandom), a, 8'($urandom), int'($urandom_range(TO - 1, 0)),
             int'($urandom_range(2, 0)), int'($urandom_range(3, 0)), -1);
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule
